// File: rtl/t05_code_translator.sv
// Codeword translator: captures a per-character codebook while in LOAD,
// then serialises the stored codeword of each accepted source byte,
// MSB of the codeword first, over a valid/ready bit stream.
module t05_code_translator (
  input  logic         clk,
  input  logic         rst,
  input  logic         char_found,
  input  logic [7:0]   char_index,
  input  logic [127:0] char_path,
  input  logic [6:0]   track_length,
  input  logic         cb_done,
  input  logic         in_valid,
  input  logic [7:0]   in_char,
  input  logic         in_last,
  output logic         in_ready,
  output logic         bit_out,
  output logic         bit_valid,
  input  logic         bit_ready,
  output logic         done,
  output logic         err_missing,
  output logic [23:0]  total_bits
);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_IDLE  = 3'd1,
    S_FETCH = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t         r_state;
  state_t         w_next_state;

  logic [255:0]   r_valid;
  logic [6:0]     r_len  [0:255];
  logic [127:0]   r_path [0:255];

  logic [7:0]     r_char;
  logic           r_last;
  logic [127:0]   r_shift;
  logic [6:0]     r_count;
  logic           r_err;
  logic [23:0]    r_total;
  logic           r_in_ready;
  logic           r_bit_valid;
  logic           r_done;

  logic           w_tbl_we;
  logic           w_fetch_hit;
  logic [6:0]     w_fetch_len;
  logic [127:0]   w_fetch_path;
  logic [7:0]     w_shift_amt;
  logic           w_bit_take;

  assign w_tbl_we     = (r_state == S_LOAD) && char_found && (track_length != 7'd0);
  assign w_fetch_hit  = r_valid[r_char];
  assign w_fetch_len  = r_len[r_char];
  assign w_fetch_path = r_path[r_char];
  // Left-align the codeword so its first bit sits at r_shift[127].
  assign w_shift_amt  = 8'd128 - {1'b0, w_fetch_len};
  assign w_bit_take   = (r_state == S_EMIT) && bit_ready;

  // Codebook payload; no reset needed because the valid bits gate every read.
  always_ff @(posedge clk) begin
    if (w_tbl_we) begin
      r_len[char_index]  <= track_length;
      r_path[char_index] <= char_path;
    end
  end

  // Codebook valid bits, cleared by reset and set on each LOAD write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= {256{1'b0}};
    end else if (w_tbl_we) begin
      r_valid[char_index] <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_LOAD: begin
        if (cb_done) w_next_state = S_IDLE;
        else         w_next_state = S_LOAD;
      end
      S_IDLE: begin
        if (in_valid) w_next_state = S_FETCH;
        else          w_next_state = S_IDLE;
      end
      S_FETCH: begin
        if (w_fetch_hit) w_next_state = S_EMIT;
        else if (r_last) w_next_state = S_DONE;
        else             w_next_state = S_IDLE;
      end
      S_EMIT: begin
        if (bit_ready && (r_count == 7'd1)) begin
          if (r_last) w_next_state = S_DONE;
          else        w_next_state = S_IDLE;
        end else begin
          w_next_state = S_EMIT;
        end
      end
      S_DONE:  w_next_state = S_DONE;
      default: w_next_state = S_LOAD;
    endcase
  end

  // Byte capture, codeword shifter, bit counter, error flag and bit total.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_char  <= 8'd0;
      r_last  <= 1'b0;
      r_shift <= 128'd0;
      r_count <= 7'd0;
      r_err   <= 1'b0;
      r_total <= 24'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_char <= in_char;
            r_last <= in_last;
          end
        end
        S_FETCH: begin
          if (w_fetch_hit) begin
            r_shift <= w_fetch_path << w_shift_amt;
            r_count <= w_fetch_len;
          end else begin
            r_err <= 1'b1;
          end
        end
        S_EMIT: begin
          if (w_bit_take) begin
            r_shift <= {r_shift[126:0], 1'b0};
            r_count <= r_count - 7'd1;
            if (r_total != 24'hFFFFFF) r_total <= r_total + 24'd1;
          end
        end
        default: begin
          r_count <= r_count;
        end
      endcase
    end
  end

  // Registered handshake/status flags, tracking the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready  <= 1'b0;
      r_bit_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_in_ready  <= (w_next_state == S_IDLE);
      r_bit_valid <= (w_next_state == S_EMIT);
      r_done      <= (w_next_state == S_DONE);
    end
  end

  assign in_ready    = r_in_ready;
  assign bit_valid   = r_bit_valid;
  assign bit_out     = r_shift[127];
  assign done        = r_done;
  assign err_missing = r_err;
  assign total_bits  = r_total;

endmodule

// File: doc/t05_code_translator.md
T05_CODE_TRANSLATOR -- requirements
Module: t05_code_translator

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port char_found, input, 1 bit: one-cycle strobe from the codebook stage; char_index, char_path and track_length are valid this cycle.
REQ-004 SHALL have port char_index, input, 8 bits: character whose codeword is presented.
REQ-005 SHALL have port char_path, input, 128 bits: codeword held in char_path[track_length-1:0]; bit [track_length-1] is transmitted first.
REQ-006 SHALL have port track_length, input, 7 bits: codeword length, 1..127.
REQ-007 SHALL have port cb_done, input, 1 bit: level, high once codebook generation is complete.
REQ-008 SHALL have port in_valid, input, 1 bit: source byte valid.
REQ-009 SHALL have port in_char, input, 8 bits: source byte.
REQ-010 SHALL have port in_last, input, 1 bit: qualifies in_char as the final byte.
REQ-011 SHALL have port in_ready, output, 1 bit: translator accepts a byte this cycle.
REQ-012 SHALL have port bit_out, output, 1 bit: current encoded bit.
REQ-013 SHALL have port bit_valid, output, 1 bit: bit_out is valid.
REQ-014 SHALL have port bit_ready, input, 1 bit: consumer accepts bit_out.
REQ-015 SHALL have port done, output, 1 bit: last code fully emitted.
REQ-016 SHALL have port err_missing, output, 1 bit: sticky; a byte with no stored code was received.
REQ-017 SHALL have port total_bits, output, 24 bits: count of accepted bits, saturating at 24'hFFFFFF.

Function
REQ-018 SHALL hold a 256-entry register table of {valid, length[6:0], path[127:0]}, indexed by character.
REQ-019 SHALL implement states LOAD, IDLE, FETCH, EMIT, DONE; after reset the state SHALL be LOAD.
REQ-020 In LOAD, char_found with track_length != 0 SHALL write the entry and set valid; a repeat index SHALL overwrite; track_length == 0 SHALL be ignored.
REQ-021 In LOAD, cb_done high SHALL move to IDLE on the next edge; char_found in that same cycle SHALL still be written.
REQ-022 Outside LOAD, char_found SHALL be ignored and the table SHALL NOT change.
REQ-023 in_ready SHALL be 1 only in IDLE; a transfer is in_valid && in_ready, which latches in_char and in_last and moves to FETCH.
REQ-024 In FETCH (one cycle), a valid entry SHALL load the shift register and bit counter and move to EMIT.
REQ-025 In FETCH, an invalid entry SHALL set err_missing, emit nothing, and move to DONE if the latched last flag is set, else to IDLE.
REQ-026 In EMIT, bit_valid SHALL be 1 and bit_out SHALL equal path[count-1].
REQ-027 bit_out SHALL hold stable while bit_valid && !bit_ready.
REQ-028 Each bit_valid && bit_ready SHALL decrement count and increment total_bits, saturating.
REQ-029 On acceptance of the bit with count == 1, the state SHALL move to DONE if last, else to IDLE.
REQ-030 Latency: a byte accepted in cycle N SHALL present its first bit_valid in cycle N+2.
REQ-031 Throughput SHALL be one bit per cycle while bit_ready is held high.
REQ-032 DONE SHALL assert done=1, keep in_ready=0 and bit_valid=0, and hold until rst.

Reset
REQ-033 On rst, regardless of clock, the block SHALL clear all table valid bits, count, total_bits and err_missing, and enter LOAD.
REQ-034 During rst, in_ready, bit_valid, bit_out, done and err_missing SHALL all be 0.
REQ-035 rst asserted mid-EMIT SHALL abort the codeword; no further bits SHALL be emitted.

Verification
REQ-036 Reset check: assert rst -> every output is 0 and in_ready stays 0 until cb_done is applied.
REQ-037 Basic encode: load 'A'(65) path 2'b10 len 2 and 'B'(66) path 3'b011 len 3; apply cb_done; send 'A' then 'B' with in_last; hold bit_ready=1 -> bits 1,0,0,1,1, then done=1 and total_bits=5.
REQ-038 Backpressure: as REQ-037, but drop bit_ready for 3 cycles at the second bit -> bit_out holds 0, sequence is unchanged, total_bits=5.
REQ-039 Missing code: send 'Z'(90), never loaded -> err_missing=1, bit_valid never asserted, in_ready=1 again 2 cycles after acceptance.
REQ-040 Maximum length: load len 127 with path[126]=1 and all other bits 0 -> 127 bits emitted, first is 1, remainder 0, total_bits=127.
REQ-041 Mid-operation reset: assert rst during EMIT of 'B' -> outputs 0 immediately; after a new cb_done with no loads, sending 'A' sets err_missing.
